cdc_fifo_src_arb: RTL and testbench

CDC_FIFO_SRC_ARB -- requirements
Module: cdc_fifo_src_arb

---
 rtl/cdc_fifo_src_arb.sv | 159 +++++++++++++++
 tb/tb_cdc_fifo_src_arb.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_fifo_src_arb.sv
// ---------------------------------------------------------------------------
// cdc_fifo_src_arb
//
// Source-side arbiter that funnels NUM_REQ requesters into the push port of a
// CDC FIFO. Selection is round-robin from a priority pointer. Once a
// requester is selected, the grant is held while the FIFO applies
// backpressure, so the presented data and index stay stable until the beat
// is accepted. The payload path is purely combinational.
//
// Build option:
//   CDC_FIFO_SRC_ARB_LOCK_EN  defined   : a beat ends a packet only when its
//                                          req_last_i bit is set, so a grant
//                                          is held for the whole packet.
//                             undefined : every accepted beat ends a packet
//                                          and req_last_i is ignored.
//
// Parameters:
//   T        payload type (same as the CDC FIFO payload type)
//   NUM_REQ  number of requesters, must be >= 2
//
// Ports:
//   src_clk_i     source-domain clock
//   src_rst_ni    asynchronous active-low reset
//   req_data_i    per-requester payload
//   req_valid_i   per-requester valid
//   req_last_i    per-requester end-of-packet flag, qualified by valid
//   req_ready_o   per-requester ready, at most one bit set
//   fifo_data_o   payload to the FIFO push port
//   fifo_valid_o  push valid
//   fifo_ready_i  push ready (FIFO not-full)
//   gnt_idx_o     index of the currently selected requester
//   busy_o        high while a grant is held across cycles
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no grant held; selection is re-arbitrated combinationally
// GRANTED | selection pinned to gnt_q until a packet-final beat transfers
// ---------------------------------------------------------------------------
module cdc_fifo_src_arb #(
  parameter type         T       = logic,
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               src_clk_i,
  input  logic               src_rst_ni,
  input  T                   req_data_i [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [NUM_REQ-1:0] req_last_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  output T                   fifo_data_o,
  output logic               fifo_valid_o,
  input  logic               fifo_ready_i,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               busy_o
);

  if (NUM_REQ < 2) begin : g_num_req_check
    $error("cdc_fifo_src_arb: NUM_REQ must be at least 2");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_found;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
  logic             xfer;
  logic             pkt_final;
  int unsigned      cand;

  // Round-robin search starting at rr_q. The modulo keeps the wrap correct
  // when NUM_REQ is not a power of two.
  always_comb begin
    arb_idx   = rr_q;
    arb_found = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_q) + k) % NUM_REQ;
      if (!arb_found && req_valid_i[IDX_W'(cand)]) begin
        arb_idx   = IDX_W'(cand);
        arb_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_idx   = arb_idx;
    sel_valid = arb_found;
    if (state_q == GRANTED) begin
      sel_idx   = gnt_q;
      sel_valid = req_valid_i[gnt_q];
    end
  end

  assign xfer = sel_valid & fifo_ready_i;

`ifdef CDC_FIFO_SRC_ARB_LOCK_EN
  assign pkt_final = req_last_i[sel_idx];
`else
  logic unused_req_last;
  assign unused_req_last = ^req_last_i;
  assign pkt_final       = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        // Hold the choice either because the FIFO stalled it or because the
        // packet continues past this beat.
        if (sel_valid && (!fifo_ready_i || !pkt_final)) begin
          state_d = GRANTED;
          gnt_d   = sel_idx;
        end
      end
      GRANTED: begin
        if (xfer && pkt_final) begin
          state_d = IDLE;
        end
      end
    endcase
    if (xfer && pkt_final) begin
      rr_d = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (xfer) begin
      req_ready_o[sel_idx] = 1'b1;
    end
  end

  assign fifo_data_o  = req_data_i[sel_idx];
  assign fifo_valid_o = sel_valid;
  assign gnt_idx_o    = sel_idx;
  assign busy_o       = (state_q == GRANTED);

endmodule

// File: tb/tb_cdc_fifo_src_arb.sv
module tb_cdc_fifo_src_arb;

`ifdef CDC_FIFO_SRC_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req_data [4];
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [3:0] req_ready;
  logic [7:0] fifo_data;
  logic       fifo_valid;
  logic       fifo_ready;
  logic [1:0] gnt_idx;
  logic       busy;

  cdc_fifo_src_arb #(
    .T       (logic [7:0]),
    .NUM_REQ (4)
  ) dut (
    .src_clk_i    (clk),
    .src_rst_ni   (rst_n),
    .req_data_i   (req_data),
    .req_valid_i  (req_valid),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready),
    .fifo_data_o  (fifo_data),
    .fifo_valid_o (fifo_valid),
    .fifo_ready_i (fifo_ready),
    .gnt_idx_o    (gnt_idx),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         last;
    bit         gap;
  } beat_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } sb_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         cyc;
  } log_t;

  beat_t rq [4][$];
  sb_t   sb [$];
  log_t  seen [$];
  bit [3:0] shown_gap;
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester drivers: each requester presents the head of its beat queue and
  // advances only after its own transfer. Gap entries drop valid for a cycle.
  bit [3:0] took;
  initial begin
    for (int i = 0; i < 4; i++) begin
      req_data[i] = '0;
    end
    req_valid = '0;
    req_last  = '0;
    shown_gap = '0;
    forever begin
      @(negedge clk);
      #1;
      took = rst_n ? req_ready : 4'b0000;
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (rq[i].size() > 0 && (took[i] || shown_gap[i])) void'(rq[i].pop_front());
        shown_gap[i] = 1'b0;
        if (rq[i].size() == 0) begin
          req_valid[i] = 1'b0;
        end else if (rq[i][0].gap) begin
          req_valid[i] = 1'b0;
          shown_gap[i] = 1'b1;
        end else begin
          req_valid[i] = 1'b1;
          req_data[i]  = rq[i][0].data;
          req_last[i]  = rq[i][0].last;
        end
      end
    end
  end

  // Reference model: a requester owns the port from the moment it is shown
  // until its packet-final beat is accepted; otherwise the first valid
  // requester at or after the priority pointer (wrapping) is shown.
  int m_rr  = 0;
  int m_own = -1;
  int e_idx;
  bit e_v;
  bit e_fin;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_rr  = 0;
      m_own = -1;
    end
    e_v   = 1'b0;
    e_idx = m_rr;
    if (m_own >= 0) begin
      e_idx = m_own;
      e_v   = req_valid[m_own];
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!e_v && req_valid[(m_rr + k) % 4]) begin
          e_v   = 1'b1;
          e_idx = (m_rr + k) % 4;
        end
      end
    end
    chk("model_gnt_idx", int'(gnt_idx), e_idx);
    chk("model_fifo_valid", int'(fifo_valid), int'(e_v));
    chk("model_busy", int'(busy), int'(m_own >= 0));
    if (e_v) chk("model_fifo_data", int'(fifo_data), int'(req_data[e_idx]));
    if (rst_n && e_v) begin
      if (fifo_ready) begin
        sb.push_back('{e_idx, req_data[e_idx]});
        e_fin = LOCK ? req_last[e_idx] : 1'b1;
        if (e_fin) begin
          m_rr  = (e_idx + 1) % 4;
          m_own = -1;
        end else begin
          m_own = e_idx;
        end
      end else begin
        m_own = e_idx;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and checks the
  // requester-side handshake rules.
  sb_t        exp_beat;
  logic [3:0] exp_ready;
  logic [3:0] prev_v;
  logic [3:0] prev_took;
  logic [7:0] prev_d [4];
  logic       prev_rst = 1'b0;
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("ready_onehot0", int'($onehot0(req_ready)), 1);
      exp_ready = (fifo_valid && fifo_ready) ? (4'b0001 << gnt_idx) : 4'b0000;
      chk("req_ready_vec", int'(req_ready), int'(exp_ready));
      if (fifo_valid && fifo_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_beat", int'(fifo_data), -1);
        end else begin
          exp_beat = sb.pop_front();
          chk("sb_data", int'(fifo_data), int'(exp_beat.data));
          chk("sb_idx", int'(gnt_idx), exp_beat.idx);
        end
        seen.push_back('{int'(gnt_idx), fifo_data, cyc});
      end
      if (prev_rst) begin
        for (int i = 0; i < 4; i++) begin
          if (prev_v[i] && !prev_took[i]) begin
            chk("req_valid_stable", int'(req_valid[i]), 1);
            chk("req_data_stable", int'(req_data[i]), int'(prev_d[i]));
          end
        end
      end
    end
    prev_rst  = rst_n;
    prev_v    = req_valid;
    prev_took = req_ready;
    for (int i = 0; i < 4; i++) prev_d[i] = req_data[i];
  end

  task automatic wait_seen(int n, int budget, string nm);
    int c;
    c = 0;
    while (seen.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk(nm, int'(seen.size() >= n), 1);
  endtask

  function automatic int seen_data(int i);
    return (i < seen.size()) ? int'(seen[i].data) : -1;
  endfunction

  function automatic int seen_idx(int i);
    return (i < seen.size()) ? seen[i].idx : -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

  logic [7:0] exp_seq [4];
  int         exp_busy [4];
  int         got_busy [4];
  bit         found;
  int         total;
  int         npk;
  int         len;
  bit         all_empty;

  initial begin
    rst_n      = 1'b0;
    fifo_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fifo_valid", int'(fifo_valid), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_gnt_idx", int'(gnt_idx), 0);
    chk("rst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;

    // All four valid with last set, FIFO always ready.
    tick();
    seen.delete();
    fifo_ready = 1'b1;
    rq[0].push_back('{8'h10, 1'b1, 1'b0});
    rq[0].push_back('{8'h14, 1'b1, 1'b0});
    rq[1].push_back('{8'h11, 1'b1, 1'b0});
    rq[2].push_back('{8'h12, 1'b1, 1'b0});
    rq[3].push_back('{8'h13, 1'b1, 1'b0});
    wait_seen(5, 20, "rr_beats_arrived");
    for (int i = 0; i < 5; i++) begin
      chk("rr_order_idx", seen_idx(i), i % 4);
      chk("rr_order_data", seen_data(i), 8'h10 + i);
      if (i < seen.size()) chk("rr_one_per_cycle", seen[i].cyc - seen[0].cyc, i);
    end

    // Backpressure: req0 held for three stalled cycles while req1 appears.
    tick();
    seen.delete();
    fifo_ready = 1'b0;
    rq[0].push_back('{8'h11, 1'b1, 1'b0});
    for (int c = 0; c < 3; c++) begin
      if (c == 1) rq[1].push_back('{8'h22, 1'b1, 1'b0});
      @(negedge clk);
      chk("bp_gnt_idx", int'(gnt_idx), 0);
      chk("bp_fifo_data", int'(fifo_data), 8'h11);
      chk("bp_fifo_valid", int'(fifo_valid), 1);
      if (c > 0) chk("bp_busy", int'(busy), 1);
      tick();
    end
    fifo_ready = 1'b1;
    wait_seen(2, 10, "bp_beats_arrived");
    chk("bp_first_data", seen_data(0), 8'h11);
    chk("bp_second_data", seen_data(1), 8'h22);
    chk("bp_second_idx", seen_idx(1), 1);

    // Three-beat packet on req2 competing with a single beat on req3,
    // priority pointer now at 2.
    tick();
    seen.delete();
    rq[2].push_back('{8'hA1, 1'b0, 1'b0});
    rq[2].push_back('{8'hA2, 1'b0, 1'b0});
    rq[2].push_back('{8'hA3, 1'b1, 1'b0});
    rq[3].push_back('{8'hB1, 1'b1, 1'b0});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      got_busy[c] = int'(busy);
      tick();
    end
    wait_seen(4, 10, "pkt_beats_arrived");
    if (LOCK) begin
      exp_seq  = '{8'hA1, 8'hA2, 8'hA3, 8'hB1};
      exp_busy = '{0, 1, 1, 0};
    end else begin
      exp_seq  = '{8'hA1, 8'hB1, 8'hA2, 8'hA3};
      exp_busy = '{0, 0, 0, 0};
    end
    for (int i = 0; i < 4; i++) begin
      chk("pkt_order", seen_data(i), int'(exp_seq[i]));
      chk("pkt_busy", got_busy[i], exp_busy[i]);
    end
    @(negedge clk);
    chk("pkt_idle_valid", int'(fifo_valid), 0);
    chk("pkt_idle_rr", int'(gnt_idx), LOCK ? 0 : 3);
    tick();

    // Same traffic again, reset hits right after 0xA2 is accepted.
    seen.delete();
    rq[2].push_back('{8'hA1, 1'b0, 1'b0});
    rq[2].push_back('{8'hA2, 1'b0, 1'b0});
    rq[2].push_back('{8'hA3, 1'b1, 1'b0});
    rq[3].push_back('{8'hB1, 1'b1, 1'b0});
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clk);
      #2;
      if (seen.size() > 0 && seen[seen.size() - 1].data == 8'hA2) found = 1'b1;
    end
    chk("mid_rst_a2_seen", int'(found), 1);
    tick();
    rst_n      = 1'b0;
    fifo_ready = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) rq[i].delete();
    shown_gap = '0;
    rq[2].push_back('{8'hC1, 1'b1, 1'b0});
    rq[3].push_back('{8'hD1, 1'b1, 1'b0});
    tick();
    tick();
    rst_n      = 1'b1;
    fifo_ready = 1'b1;
    seen.delete();
    @(negedge clk);
    chk("post_rst_gnt", int'(gnt_idx), 2);
    tick();
    wait_seen(2, 10, "post_rst_beats");
    chk("post_rst_first", seen_data(0), 8'hC1);
    chk("post_rst_second", seen_data(1), 8'hD1);

    // Randomized packets, gaps and backpressure.
    tick();
    seen.delete();
    total = 0;
    for (int i = 0; i < 4; i++) begin
      npk = $urandom_range(4, 2);
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(3, 1);
        for (int b = 0; b < len; b++) begin
          rq[i].push_back('{8'($urandom),
                            LOCK ? (b == len - 1) : 1'($urandom_range(1, 0)),
                            1'b0});
          if (b < len - 1 && $urandom_range(3, 0) == 0) rq[i].push_back('{8'h00, 1'b0, 1'b1});
        end
        total += len;
      end
    end
    for (int c = 0; c < 3000; c++) begin
      fifo_ready = ($urandom_range(3, 0) != 0);
      tick();
      all_empty = 1'b1;
      for (int i = 0; i < 4; i++) if (rq[i].size() != 0) all_empty = 1'b0;
      if (all_empty) break;
    end
    fifo_ready = 1'b1;
    repeat (3) tick();
    chk("rand_beat_count", seen.size(), total);
    chk("rand_sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
